// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - FSM controller for a multicycle MIPS datapath
//
// Sequences fetch/decode/execute/memory/writeback over one shared memory,
// stalling on mem_ready, trapping on illegal op/funct or memory timeout,
// and counting retired instructions.
//
// Ports
//   clk, reset            clock; synchronous active-high reset
//   op, funct             IR[31:26], IR[5:0]
//   zero                  ALU zero flag (branch condition)
//   mem_ready             memory completes the current access this cycle
//   iord .. pcen          datapath control (mux selects and write enables)
//   instr_done            one-cycle pulse on an instruction's final cycle
//   error                 high while trapped
//   instret               retired-instruction count, wraps modulo 2^CNT_W
module multicycle_ctrl #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             iord,
    output logic             memwrite,
    output logic             irwrite,
    output logic             regdst,
    output logic             memtoreg,
    output logic             regwrite,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic             signzero,
    output logic [2:0]       alucontrol,
    output logic [1:0]       pcsrc,
    output logic             pcen,
    output logic             instr_done,
    output logic             error,
    output logic [CNT_W-1:0] instret
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // The counter only has to reach TIMEOUT-1: the wait cycle that would
    // bring it to TIMEOUT is the one that traps instead.
    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_RTYPE,
        S_ALUWB, S_BRANCH, S_ADDIEX, S_ORIEX, S_IMMWB, S_JUMP, S_TRAP
    } state_t;

    state_t            r_state;
    logic [WAIT_W-1:0] r_wait;
    logic [CNT_W-1:0]  r_instret;
    logic              w_wait_expired;
    logic              w_funct_ok;
    logic [2:0]        w_r_alu;

    assign instret        = r_instret;
    assign w_wait_expired = (TIMEOUT != 0) && (r_wait == WAIT_W'(TIMEOUT - 1));

    // R-type funct decode; anything unlisted (including x) is illegal.
    always_comb begin
        w_funct_ok = 1'b1;
        w_r_alu    = ALU_ADD;
        case (funct)
            6'b100000: w_r_alu = ALU_ADD;
            6'b100010: w_r_alu = ALU_SUB;
            6'b100100: w_r_alu = ALU_AND;
            6'b100101: w_r_alu = ALU_OR;
            6'b101010: w_r_alu = ALU_SLT;
            default:   w_funct_ok = 1'b0;
        endcase
    end

    // State, wait counter and retire counter. The wait counter is cleared on
    // every cycle that is not a stalled wait, so it is zero on entry to any
    // wait state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_wait    <= '0;
            r_instret <= '0;
        end else begin
            r_wait <= '0;
            if (instr_done) begin
                r_instret <= r_instret + CNT_W'(1);
            end
            case (r_state)
                S_FETCH: begin
                    if (mem_ready)           r_state <= S_DECODE;
                    else if (w_wait_expired) r_state <= S_TRAP;
                    else                     r_wait  <= r_wait + WAIT_W'(1);
                end
                S_DECODE: begin
                    case (op)
                        OP_RTYPE:     r_state <= w_funct_ok ? S_RTYPE : S_TRAP;
                        OP_LW, OP_SW: r_state <= S_MEMADR;
                        OP_BEQ, OP_BNE: r_state <= S_BRANCH;
                        OP_ADDI:      r_state <= S_ADDIEX;
                        OP_ORI:       r_state <= S_ORIEX;
                        OP_J:         r_state <= S_JUMP;
                        default:      r_state <= S_TRAP;
                    endcase
                end
                S_MEMADR: begin
                    if (op == OP_LW)      r_state <= S_MEMRD;
                    else if (op == OP_SW) r_state <= S_MEMWR;
                    else                  r_state <= S_TRAP;
                end
                S_MEMRD: begin
                    if (mem_ready)           r_state <= S_MEMWB;
                    else if (w_wait_expired) r_state <= S_TRAP;
                    else                     r_wait  <= r_wait + WAIT_W'(1);
                end
                S_MEMWR: begin
                    if (mem_ready)           r_state <= S_FETCH;
                    else if (w_wait_expired) r_state <= S_TRAP;
                    else                     r_wait  <= r_wait + WAIT_W'(1);
                end
                S_RTYPE:                   r_state <= S_ALUWB;
                S_ADDIEX, S_ORIEX:         r_state <= S_IMMWB;
                S_MEMWB, S_ALUWB, S_BRANCH,
                S_IMMWB, S_JUMP:           r_state <= S_FETCH;
                S_TRAP:                    r_state <= S_TRAP;
                default:                   r_state <= S_TRAP;
            endcase
        end
    end

    // Datapath controls decoded from state (plus mem_ready/op/zero).
    always_comb begin
        iord       = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        signzero   = 1'b0;
        alucontrol = ALU_AND;
        pcsrc      = 2'b00;
        pcen       = 1'b0;
        instr_done = 1'b0;
        error      = 1'b0;
        case (r_state)
            S_FETCH: begin
                alusrcb    = 2'b01;
                alucontrol = ALU_ADD;
                if (mem_ready) begin
                    irwrite = 1'b1;
                    pcen    = 1'b1;
                end
            end
            S_DECODE: begin
                alusrcb    = 2'b11;
                alucontrol = ALU_ADD;
            end
            S_MEMADR: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                alucontrol = ALU_ADD;
            end
            S_MEMRD: iord = 1'b1;
            S_MEMWB: begin
                memtoreg   = 1'b1;
                regwrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                iord       = 1'b1;
                memwrite   = 1'b1;
                instr_done = mem_ready;
            end
            S_RTYPE: begin
                alusrca    = 1'b1;
                alucontrol = w_r_alu;
            end
            S_ALUWB: begin
                regdst     = 1'b1;
                regwrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alusrca    = 1'b1;
                alucontrol = ALU_SUB;
                pcsrc      = 2'b01;
                instr_done = 1'b1;
                // if/else rather than an expression so an unknown op gives 0
                if (op == OP_BEQ)      pcen = zero;
                else if (op == OP_BNE) pcen = ~zero;
            end
            S_ADDIEX: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                alucontrol = ALU_ADD;
            end
            S_ORIEX: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                alucontrol = ALU_OR;
                signzero   = 1'b1;
            end
            S_IMMWB: begin
                regwrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_JUMP: begin
                pcsrc      = 2'b10;
                pcen       = 1'b1;
                instr_done = 1'b1;
            end
            S_TRAP: error = 1'b1;
            default: ;
        endcase
        if (reset) begin
            pcen       = 1'b0;
            irwrite    = 1'b0;
            regwrite   = 1'b0;
            memwrite   = 1'b0;
            instr_done = 1'b0;
            error      = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - scoreboard bench for multicycle_ctrl
module tb_multicycle_ctrl;

    localparam int CNT_W = 4;
    localparam int TO    = 4;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_J    = 6'b000010;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [5:0]       op = '0;
    logic [5:0]       funct = '0;
    logic             zero = 1'b0;
    logic             mem_ready = 1'b0;
    logic             iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0]       alusrcb;
    logic             signzero;
    logic [2:0]       alucontrol;
    logic [1:0]       pcsrc;
    logic             pcen, instr_done, error;
    logic [CNT_W-1:0] instret;

    multicycle_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .iord(iord), .memwrite(memwrite),
        .irwrite(irwrite), .regdst(regdst), .memtoreg(memtoreg),
        .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
        .signzero(signzero), .alucontrol(alucontrol), .pcsrc(pcsrc),
        .pcen(pcen), .instr_done(instr_done), .error(error), .instret(instret)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        bit       trap;
        int       cyc;
        int       n_pcen;
        int       n_irw;
        int       n_memw;
        int       n_regw;
        bit       memtoreg;
        bit       regdst;
        bit       iord;
        bit [1:0] pcsrc;
        bit [2:0] alu;
        bit [2:0] prev_alu;
        bit       prev_sz;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ALU code an R-type funct asks for; returns 0 for an unsupported funct.
    function automatic bit r_alu(input logic [5:0] fn, output bit [2:0] code);
        code = 3'b000;
        case (fn)
            6'h20: begin code = 3'b010; return 1; end
            6'h22: begin code = 3'b110; return 1; end
            6'h24: begin code = 3'b000; return 1; end
            6'h25: begin code = 3'b001; return 1; end
            6'h2a: begin code = 3'b111; return 1; end
            default: return 0;
        endcase
    endfunction

    // Instruction-level reference: f fetch wait cycles, m memory wait cycles.
    // Cycles are numbered from 1 at the first FETCH cycle; cyc is the cycle on
    // which instr_done pulses, or the first cycle showing error.
    function automatic exp_t model(input logic [5:0] o, input logic [5:0] fn,
                                   input bit z, input int f, input int m);
        exp_t     e;
        bit [2:0] code;
        e = '0;
        if (f >= TO) begin
            e.trap = 1; e.cyc = TO + 1;
            return e;
        end
        e.n_irw  = 1;
        e.n_pcen = 1;
        case (o)
            OP_LW: if (m >= TO) begin
                e.trap = 1; e.cyc = f + 4 + TO;
            end else begin
                e.cyc = f + m + 5; e.n_regw = 1; e.memtoreg = 1;
            end
            OP_SW: if (m >= TO) begin
                e.trap = 1; e.cyc = f + 4 + TO; e.n_memw = TO;
            end else begin
                e.cyc = f + m + 4; e.n_memw = m + 1; e.iord = 1;
                e.prev_alu = (m == 0) ? 3'b010 : 3'b000;
            end
            OP_R: if (r_alu(fn, code)) begin
                e.cyc = f + 4; e.n_regw = 1; e.regdst = 1; e.prev_alu = code;
            end else begin
                e.trap = 1; e.cyc = f + 3;
            end
            OP_BEQ, OP_BNE: begin
                e.cyc = f + 3; e.pcsrc = 2'b01; e.alu = 3'b110; e.prev_alu = 3'b010;
                if ((o == OP_BEQ && z) || (o == OP_BNE && !z)) e.n_pcen = 2;
            end
            OP_ADDI: begin e.cyc = f + 4; e.n_regw = 1; e.prev_alu = 3'b010; end
            OP_ORI:  begin e.cyc = f + 4; e.n_regw = 1; e.prev_alu = 3'b001; e.prev_sz = 1; end
            OP_J:    begin e.cyc = f + 3; e.n_pcen = 2; e.pcsrc = 2'b10; e.prev_alu = 3'b010; end
            default: begin e.trap = 1; e.cyc = f + 3; end
        endcase
        return e;
    endfunction

    task automatic cyc_drive(input bit r);
        mem_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Drives one instruction; abort_at > 0 asserts reset after that many cycles.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] fn, input bit z,
                             input int f, input int m, input int abort_at = 0);
        exp_t e;
        bit   is_mem;
        bit   r;
        int   n;
        e      = model(o, fn, z, f, m);
        is_mem = (f < TO) && (o == OP_LW || o == OP_SW);
        op = o; funct = fn; zero = z;
        if (abort_at == 0) sb_q.push_back(e);
        n = (abort_at != 0) ? abort_at : e.cyc;
        for (int c = 1; c <= n; c++) begin
            r = 1'($urandom % 2);
            if (c <= f + 1)               r = (c == f + 1);
            else if (is_mem && c >= f + 4) r = (c == f + 4 + m);
            cyc_drive(r);
        end
        if (abort_at != 0) begin
            do_reset();
        end else if (e.trap) begin
            cyc_drive(1'b1);
            cyc_drive(1'b0);
            do_reset();
        end
    endtask

    // Monitor: accumulates per-instruction activity and checks it against the
    // scoreboard whenever the DUT signals completion or a trap.
    int       mon_cyc, mon_pcen, mon_irw, mon_memw, mon_regw, mon_cnt;
    bit       mon_in_trap, mon_post_rst;
    logic [2:0] mon_prev_alu;
    logic     mon_prev_sz;
    exp_t     mon_e;

    initial begin : monitor
        mon_cyc = 0; mon_pcen = 0; mon_irw = 0; mon_memw = 0; mon_regw = 0; mon_cnt = 0;
        mon_in_trap = 0; mon_post_rst = 0; mon_prev_alu = '0; mon_prev_sz = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                chk("reset_enables", {26'd0, pcen, irwrite, regwrite, memwrite, instr_done, error}, 32'd0);
                mon_cyc = 0; mon_pcen = 0; mon_irw = 0; mon_memw = 0; mon_regw = 0;
                mon_cnt = 0; mon_in_trap = 0; mon_post_rst = 1;
            end else begin
                mon_cyc++;
                mon_pcen += int'(pcen);
                mon_irw  += int'(irwrite);
                mon_memw += int'(memwrite);
                mon_regw += int'(regwrite);
                if (mon_post_rst) begin
                    chk("post_reset_fetch", {28'd0, iord, alusrca, alusrcb}, 32'h1);
                    chk("post_reset_instret", 32'(instret), 32'd0);
                    mon_post_rst = 0;
                end
                if (mon_in_trap) begin
                    chk("trap_hold", {26'd0, error, pcen, irwrite, regwrite, memwrite, instr_done}, 32'h20);
                end else if (instr_done || error) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected_response", 32'd1, 32'd0);
                    end else begin
                        mon_e = sb_q.pop_front();
                        chk("trap_flag", 32'(error), 32'(mon_e.trap));
                        chk("cycles", 32'(mon_cyc), 32'(mon_e.cyc));
                        chk("pcen_count", 32'(mon_pcen), 32'(mon_e.n_pcen));
                        chk("irwrite_count", 32'(mon_irw), 32'(mon_e.n_irw));
                        chk("memwrite_count", 32'(mon_memw), 32'(mon_e.n_memw));
                        chk("regwrite_count", 32'(mon_regw), 32'(mon_e.n_regw));
                        chk("instret", 32'(instret), 32'(mon_cnt));
                        if (!mon_e.trap) begin
                            chk("memtoreg", 32'(memtoreg), 32'(mon_e.memtoreg));
                            chk("regdst", 32'(regdst), 32'(mon_e.regdst));
                            chk("iord", 32'(iord), 32'(mon_e.iord));
                            chk("pcsrc", 32'(pcsrc), 32'(mon_e.pcsrc));
                            chk("alucontrol", 32'(alucontrol), 32'(mon_e.alu));
                            chk("exec_alucontrol", 32'(mon_prev_alu), 32'(mon_e.prev_alu));
                            chk("exec_signzero", 32'(mon_prev_sz), 32'(mon_e.prev_sz));
                            mon_cnt = (mon_cnt + 1) % (1 << CNT_W);
                        end else begin
                            mon_in_trap = 1;
                        end
                    end
                    mon_cyc = 0; mon_pcen = 0; mon_irw = 0; mon_memw = 0; mon_regw = 0;
                end else if (mon_cyc > 64) begin
                    chk("response_watchdog", 32'(mon_cyc), 32'd64);
                    mon_cyc = 0;
                end
                mon_prev_alu = alucontrol;
                mon_prev_sz  = signzero;
            end
        end
    end

    initial begin : global_limit
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    logic [5:0] rop, rfn;
    int         rf, rm;

    initial begin : stimulus
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        run_instr(OP_LW,   6'h00, 1'b0, 0, 0);
        run_instr(OP_BNE,  6'h00, 1'b0, 0, 0);
        run_instr(OP_BNE,  6'h00, 1'b1, 0, 0);
        run_instr(OP_BEQ,  6'h00, 1'b1, 1, 0);
        run_instr(OP_BEQ,  6'h00, 1'b0, 0, 0);
        run_instr(OP_SW,   6'h00, 1'b0, 0, 3);
        run_instr(OP_J,    6'h00, 1'b0, 2, 0);
        run_instr(OP_ADDI, 6'h00, 1'b0, 3, 0);
        run_instr(OP_LW,   6'h00, 1'b0, 0, 3);
        run_instr(OP_ADDI, 6'h00, 1'b0, 6, 0);
        run_instr(OP_R,    6'b100111, 1'b0, 0, 0);
        run_instr(6'b111111, 6'h20, 1'b0, 0, 0);
        run_instr(OP_ORI,  6'h00, 1'b0, 0, 0);
        run_instr(OP_R,    6'h20, 1'b0, 0, 0);
        run_instr(OP_R,    6'h22, 1'b0, 1, 0);
        run_instr(OP_R,    6'h24, 1'b0, 0, 0);
        run_instr(OP_R,    6'h25, 1'b0, 0, 0);
        run_instr(OP_R,    6'h2a, 1'b0, 0, 0);
        run_instr(OP_SW,   6'h00, 1'b0, 0, 4);
        run_instr(OP_LW,   6'h00, 1'b0, 1, 5);
        run_instr(OP_SW,   6'h00, 1'b0, 0, 3, 5);
        for (int i = 0; i < 18; i++) run_instr(OP_ADDI, 6'h00, 1'b0, 0, 0);

        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 10))
                0: rop = OP_R;    1: rop = OP_LW;   2: rop = OP_SW;
                3: rop = OP_BEQ;  4: rop = OP_BNE;  5: rop = OP_ADDI;
                6: rop = OP_ORI;  7: rop = OP_J;    8: rop = OP_R;
                9: rop = OP_LW;
                default: rop = 6'($urandom);
            endcase
            case ($urandom_range(0, 5))
                0: rfn = 6'h20; 1: rfn = 6'h22; 2: rfn = 6'h24;
                3: rfn = 6'h25; 4: rfn = 6'h2a;
                default: rfn = 6'($urandom);
            endcase
            rf = ($urandom_range(0, 9) == 0) ? $urandom_range(4, 6) : $urandom_range(0, 3);
            rm = ($urandom_range(0, 9) == 0) ? $urandom_range(4, 6) : $urandom_range(0, 3);
            run_instr(rop, rfn, 1'($urandom % 2), rf, rm);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
